// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port memory between fetch and load/store ports
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              owner_d;
    logic              last_d;
    logic [CNT_W-1:0]  cnt;
    logic              pick_if;
    logic              pick_d;
    logic              start;
    logic              done_ok;
    logic              done_to;

    // Arbitration: a lone requester wins; on a tie the port not granted last time wins.
    always_comb begin
        pick_d  = d_req && (!if_req || !last_d);
        pick_if = if_req && (!d_req || last_d);
        start   = (state == IDLE) && (pick_d || pick_if);
        done_ok = (state == ACCESS) && mem_ready;
        done_to = (state == ACCESS) && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave IDLE on a transfer, return when the access completes or aborts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCESS;
            ACCESS:  if (done_ok || done_to) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: grants only in IDLE, memory bus driven from the latches only in ACCESS.
    always_comb begin
        if_gnt    = (state == IDLE) && pick_if;
        d_gnt     = (state == IDLE) && pick_d;
        mem_en    = (state == ACCESS);
        mem_we    = (state == ACCESS) && we_q;
        mem_addr  = (state == ACCESS) ? addr_q : '0;
        mem_wdata = (state == ACCESS) ? wdata_q : '0;
        busy      = (state == ACCESS);
    end

    // Request latches, timeout counter, response registers and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            cnt       <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (start) begin
                addr_q  <= (pick_d ? d_addr : if_addr) & ~ADDR_W'(3);
                we_q    <= pick_d && d_we;
                wdata_q <= pick_d ? d_wdata : '0;
                owner_d <= pick_d;
                last_d  <= pick_d;
                cnt     <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (done_ok || done_to) begin
                if (owner_d) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= (done_ok && !we_q) ? mem_rdata : '0;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= done_ok ? mem_rdata : '0;
                end
            end
            if (done_to) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbiter and sequencer that shares one single-port unified memory between the instruction-fetch path (PC/instruction side) and the load/store path (ALU_Result address, ReadData2 write data). It accepts one request at a time through req/gnt handshakes, drives the memory until mem_ready, and returns read data with a one-cycle rvalid pulse. It sits between Program_Counter/Register_File/ALU and the memory. It is required once the core moves from separate instruction/data memories to a shared memory.

Parameters:
ADDR_W, 32, address width of both ports and memory
DATA_W, 32, data width
TIMEOUT, 16, max ACCESS cycles waiting for mem_ready before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request, held until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data accepted this cycle (combinational)
d_rvalid  out  1  one-cycle pulse: load data valid / store acknowledged
d_rdata  out  DATA_W  load data (0 for stores)
mem_en  out  1  memory access active
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  word address, bits [1:0] forced 0
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completes access this cycle
busy  out  1  state != IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, latched addr/we/wdata=0, timeout counter=0, err=0, last_grant=IF. Any in-flight access is dropped; no rvalid is produced for it.
- States: IDLE, ACCESS.
- IDLE: gnt is combinational. Only one requester active: that requester is granted. Both active: the requester not in last_grant is granted. After reset this means data wins the first tie.
- Transfer occurs on the edge where req&gnt. On that edge: latch addr (low 2 bits cleared), we (forced 0 for IF), wdata; record owner and last_grant; counter=0; go to ACCESS.
- IDLE: mem_en=mem_we=0. mem_ready is ignored.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latches, held stable for the whole access. Both gnts=0. Counter increments each cycle.
- ACCESS with mem_ready=1: capture mem_rdata; next cycle, owner's rvalid=1 for exactly one cycle. rdata = captured value for a read, 0 for a store. State returns to IDLE.
- Minimum latency: gnt at cycle 0, mem_en at cycle 1, mem_ready at cycle 1, rvalid at cycle 2. A new gnt is allowed in the rvalid cycle (back-to-back access every 2 cycles).
- rdata holds its value until the next rvalid of that port. The other port's rvalid stays 0.
- Timeout: if the counter reaches TIMEOUT-1 with no mem_ready, abort the access. Next cycle: owner's rvalid=1, rdata=0, err=1 (sticky until reset), state returns to IDLE.
- mem_ready and timeout in the same cycle: mem_ready wins, no err.
- Requests arriving during ACCESS are not granted. The requester holds req; arbitration occurs on return to IDLE.
- Deasserting req before gnt is legal (request withdrawn, no side effects).

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0010, mem_ready at first ACCESS cycle, mem_rdata=0x0050_0093 -> if_gnt cycle 0; mem_en=1, mem_addr=0x10 cycle 1; if_rvalid=1, if_rdata=0x0050_0093 cycle 2; busy=0 cycle 2.
- Store: d_req=1, d_we=1, d_addr=0x0000_0103, d_wdata=0xDEAD_BEEF, mem_ready after 3 cycles -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF held 3 cycles; then d_rvalid=1, d_rdata=0.
- Contention after reset: if_req and d_req both high from cycle 0, mem_ready always 1 -> grants D, IF, D, IF alternating every 2 cycles; each rvalid goes only to its owner.
- Timeout: TIMEOUT=16, d_req load, mem_ready held 0 -> mem_en high 16 cycles; then d_rvalid=1, d_rdata=0, err=1, stays 1 across further successful accesses.
- Reset mid-access: assert reset=0 during ACCESS -> mem_en, busy, err, rvalid=0 immediately (async); after release, no rvalid for the dropped access; next tie grants data.
- mem_ready coincides with last timeout cycle -> normal completion, data returned, err remains 0.
